// File: rtl/obi_tg_master.sv
// OBI initiator traffic generator: writes TEST_WORDS pattern words from BASE_ADDR, reads them back, counts mismatches.
// Latency: request rises one cycle after entering a request state; 3 cycles/word minimum, 6*TEST_WORDS start-to-done.
// Backpressure: holds req/addr/we/be/wdata stable until gnt; one outstanding transaction; aborts after TIMEOUT idle cycles.
module obi_tg_master #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    TEST_WORDS = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [31:0]           SEED       = 32'hA5A5_0001,
  parameter int                    TIMEOUT    = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    pass_o,
  output logic                    timeout_o,
  output logic [7:0]              err_cnt_o,
  output logic                    obi_req_o,
  input  logic                    obi_gnt_i,
  output logic [ADDR_WIDTH-1:0]   obi_addr_o,
  output logic                    obi_we_o,
  output logic [DATA_WIDTH/8-1:0] obi_be_o,
  output logic [DATA_WIDTH-1:0]   obi_wdata_o,
  input  logic                    obi_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   obi_rdata_i
);

  localparam int BPW = DATA_WIDTH / 8;
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, DONE} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              k_q, k_d;
  logic [7:0]              err_q, err_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    timeout_q, timeout_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic                    busy_q, busy_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [BPW-1:0]          be_q, be_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

  logic gnt_ok, last_word, tmo_hit, in_req_d, active_q;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [7:0] k);
    return DATA_WIDTH'(SEED) + DATA_WIDTH'(k);
  endfunction

  // Next-state, word index, error count and registered OBI request fields
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    err_d     = err_q;
    timeout_d = timeout_q;
    // A grant only counts while our request is actually visible on the bus
    gnt_ok    = req_q & obi_gnt_i;
    last_word = (k_q == 8'(TEST_WORDS - 1));
    tmo_hit   = (timer_q == TW'(TIMEOUT - 1));
    active_q  = (state_q == WR_REQ) || (state_q == WR_RSP) ||
                (state_q == RD_REQ) || (state_q == RD_RSP);

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d   = WR_REQ;
          k_d       = 8'd0;
          err_d     = 8'd0;
          timeout_d = 1'b0;
        end
      end
      WR_REQ: begin
        if (gnt_ok)       state_d = WR_RSP;
        else if (tmo_hit) begin state_d = DONE; timeout_d = 1'b1; end
      end
      WR_RSP: begin
        if (obi_rvalid_i) begin
          if (last_word) begin state_d = RD_REQ; k_d = 8'd0; end
          else           begin state_d = WR_REQ; k_d = k_q + 8'd1; end
        end else if (tmo_hit) begin
          state_d = DONE; timeout_d = 1'b1;
        end
      end
      RD_REQ: begin
        if (gnt_ok)       state_d = RD_RSP;
        else if (tmo_hit) begin state_d = DONE; timeout_d = 1'b1; end
      end
      RD_RSP: begin
        if (obi_rvalid_i) begin
          if ((obi_rdata_i != pattern(k_q)) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
          if (last_word) state_d = DONE;
          else begin state_d = RD_REQ; k_d = k_q + 8'd1; end
        end else if (tmo_hit) begin
          state_d = DONE; timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Timer restarts on every state change so each REQ/RSP phase gets its own budget
    if (state_d != state_q) timer_d = '0;
    else if (active_q)      timer_d = timer_q + TW'(1);
    else                    timer_d = '0;

    // Request fields are loaded on entry; req itself rises one cycle later and
    // drops on the edge that leaves the request state (grant or timeout)
    in_req_d = (state_d == WR_REQ) || (state_d == RD_REQ);
    req_d    = in_req_d && (state_d == state_q);
    we_d     = (state_d == WR_REQ);
    be_d     = in_req_d ? '1 : '0;
    addr_d   = in_req_d ? (BASE_ADDR + ADDR_WIDTH'(k_d) * ADDR_WIDTH'(BPW)) : '0;
    wdata_d  = (state_d == WR_REQ) ? pattern(k_d) : '0;

    busy_d = (state_d == WR_REQ) || (state_d == WR_RSP) ||
             (state_d == RD_REQ) || (state_d == RD_RSP);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_d == 8'd0) && !timeout_d;
  end

  // State and output registers; reset drops req immediately and abandons the pass
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      k_q       <= 8'd0;
      err_q     <= 8'd0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      busy_q    <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      err_q     <= err_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      busy_q    <= busy_d;
      req_q     <= req_d;
      we_q      <= we_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign timeout_o   = done_q & timeout_q;
  assign err_cnt_o   = err_q;
  assign obi_req_o   = req_q;
  assign obi_we_o    = we_q;
  assign obi_be_o    = be_q;
  assign obi_addr_o  = addr_q;
  assign obi_wdata_o = wdata_q;

endmodule

// File: tb/tb_obi_tg_master.sv
module tb_obi_tg_master;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start6 = 1'b0;
  always #5 clk = ~clk;

  // Main instance: defaults (8 words from 0x0)
  logic        busy, done, pass, tmo, req, gnt, we, rvalid;
  logic [7:0]  err;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;

  obi_tg_master dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
    .pass_o(pass), .timeout_o(tmo), .err_cnt_o(err), .obi_req_o(req), .obi_gnt_i(gnt),
    .obi_addr_o(addr), .obi_we_o(we), .obi_be_o(be), .obi_wdata_o(wdata),
    .obi_rvalid_i(rvalid), .obi_rdata_i(rdata)
  );

  // Second instance: 4 words starting just below the top of the address space
  logic        busy6, done6, pass6, tmo6, req6, we6, rvalid6;
  logic [7:0]  err6;
  logic [31:0] addr6, wdata6, rdata6;
  logic [3:0]  be6;

  obi_tg_master #(.TEST_WORDS(4), .BASE_ADDR(32'hFFFF_FFF8)) dut6 (
    .clk_i(clk), .rst_i(rst), .start_i(start6), .busy_o(busy6), .done_o(done6),
    .pass_o(pass6), .timeout_o(tmo6), .err_cnt_o(err6), .obi_req_o(req6), .obi_gnt_i(1'b1),
    .obi_addr_o(addr6), .obi_we_o(we6), .obi_be_o(be6), .obi_wdata_o(wdata6),
    .obi_rvalid_i(rvalid6), .obi_rdata_i(rdata6)
  );

  // Responder for the main instance: memory, optional grant delay, never-grant, read corruption
  int gnt_wait = 0;
  bit never_gnt = 1'b0;
  int corrupt_k = -1;
  int wcnt = 0;
  int wr_n = 0, rd_n = 0, stab_err = 0;
  logic [31:0] mem [8];
  logic [31:0] wr_addr_log [256], wr_data_log [256], rd_addr_log [256];
  logic        stall_q = 1'b0, we_p = 1'b0;
  logic [31:0] addr_p = '0, wdata_p = '0;

  assign gnt = req && !never_gnt && (wcnt >= gnt_wait);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid  <= 1'b0;
      wcnt    <= 0;
      stall_q <= 1'b0;
    end else begin
      rvalid <= req && gnt;
      if (req && gnt) begin
        wcnt <= 0;
        if (we) begin
          mem[addr[4:2]]          <= wdata;
          wr_addr_log[wr_n[7:0]]  <= addr;
          wr_data_log[wr_n[7:0]]  <= wdata;
          wr_n                    <= wr_n + 1;
        end else begin
          rdata                   <= mem[addr[4:2]] ^ {31'b0, (int'(addr[4:2]) == corrupt_k)};
          rd_addr_log[rd_n[7:0]]  <= addr;
          rd_n                    <= rd_n + 1;
        end
      end else if (req) begin
        wcnt <= wcnt + 1;
      end
      if (stall_q && (!req || addr != addr_p || wdata != wdata_p || we != we_p || be != 4'hF))
        stab_err <= stab_err + 1;
      stall_q <= req && !gnt;
      addr_p  <= addr;
      wdata_p <= wdata;
      we_p    <= we;
    end
  end

  // Responder for the second instance: gnt tied high, rvalid one cycle after grant
  logic [31:0] mem6 [8];
  logic [31:0] w6_log [8], r6_log [8];
  int w6_n = 0, r6_n = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid6 <= 1'b0;
    end else begin
      rvalid6 <= req6;
      if (req6) begin
        if (we6) begin
          mem6[addr6[4:2]]  <= wdata6;
          w6_log[w6_n[2:0]] <= addr6;
          w6_n              <= w6_n + 1;
        end else begin
          rdata6            <= mem6[addr6[4:2]];
          r6_log[r6_n[2:0]] <= addr6;
          r6_n              <= r6_n + 1;
        end
      end
    end
  end

  int checks = 0, errors = 0;

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Counts clock edges after the start edge until done, bounded by limit
  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (!done && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (pass !== 1'b0)  begin errors++; $display("FAIL reset_pass got %b want 0", pass); end
    checks++; if (tmo !== 1'b0)   begin errors++; $display("FAIL reset_timeout got %b want 0", tmo); end
    checks++; if (err !== 8'd0)   begin errors++; $display("FAIL reset_err got %0d want 0", err); end
    checks++; if (req !== 1'b0)   begin errors++; $display("FAIL reset_req got %b want 0", req); end
    checks++; if (be !== 4'h0)    begin errors++; $display("FAIL reset_be got %h want 0", be); end
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", addr); end
    checks++; if (wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", wdata); end
    checks++; if (req6 !== 1'b0)  begin errors++; $display("FAIL reset_req6 got %b want 0", req6); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int cyc, wb, rb;
    wb = wr_n; rb = rd_n;
    pulse_start();
    wait_done(200, cyc);
    checks++; if (cyc !== 48)     begin errors++; $display("FAIL basic_latency got %0d want 48", cyc); end
    checks++; if (done !== 1'b1)  begin errors++; $display("FAIL basic_done got %b want 1", done); end
    checks++; if (pass !== 1'b1)  begin errors++; $display("FAIL basic_pass got %b want 1", pass); end
    checks++; if (err !== 8'd0)   begin errors++; $display("FAIL basic_err got %0d want 0", err); end
    checks++; if (tmo !== 1'b0)   begin errors++; $display("FAIL basic_timeout got %b want 0", tmo); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL basic_busy got %b want 0", busy); end
    checks++; if (wr_n - wb !== 8) begin errors++; $display("FAIL basic_wr_count got %0d want 8", wr_n - wb); end
    checks++; if (rd_n - rb !== 8) begin errors++; $display("FAIL basic_rd_count got %0d want 8", rd_n - rb); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (wr_addr_log[(wb + k) % 256] !== 32'(k * 4)) begin
        errors++; $display("FAIL basic_wr_addr%0d got %h want %h", k, wr_addr_log[(wb + k) % 256], k * 4);
      end
      checks++;
      if (wr_data_log[(wb + k) % 256] !== 32'hA5A5_0001 + 32'(k)) begin
        errors++; $display("FAIL basic_wr_data%0d got %h want %h", k, wr_data_log[(wb + k) % 256], 32'hA5A5_0001 + 32'(k));
      end
      checks++;
      if (rd_addr_log[(rb + k) % 256] !== 32'(k * 4)) begin
        errors++; $display("FAIL basic_rd_addr%0d got %h want %h", k, rd_addr_log[(rb + k) % 256], k * 4);
      end
    end
    repeat (3) @(posedge clk); #1;
    checks++; if (done !== 1'b1)  begin errors++; $display("FAIL basic_done_held got %b want 1", done); end
  endtask

  task automatic test_corrupt();
    int cyc;
    corrupt_k = 3;
    pulse_start();
    wait_done(200, cyc);
    corrupt_k = -1;
    checks++; if (done !== 1'b1)  begin errors++; $display("FAIL corrupt_done got %b want 1", done); end
    checks++; if (err !== 8'd1)   begin errors++; $display("FAIL corrupt_err got %0d want 1", err); end
    checks++; if (pass !== 1'b0)  begin errors++; $display("FAIL corrupt_pass got %b want 0", pass); end
    checks++; if (tmo !== 1'b0)   begin errors++; $display("FAIL corrupt_timeout got %b want 0", tmo); end
  endtask

  task automatic test_gnt_stall();
    int cyc, sb;
    sb = stab_err;
    gnt_wait = 5;
    pulse_start();
    wait_done(500, cyc);
    gnt_wait = 0;
    checks++; if (cyc !== 128)    begin errors++; $display("FAIL stall_latency got %0d want 128", cyc); end
    checks++; if (stab_err - sb !== 0) begin errors++; $display("FAIL stall_stability got %0d want 0", stab_err - sb); end
    checks++; if (pass !== 1'b1)  begin errors++; $display("FAIL stall_pass got %b want 1", pass); end
    checks++; if (err !== 8'd0)   begin errors++; $display("FAIL stall_err got %0d want 0", err); end
  endtask

  task automatic test_timeout();
    int cyc;
    never_gnt = 1'b1;
    pulse_start();
    wait_done(200, cyc);
    never_gnt = 1'b0;
    checks++; if (cyc !== 64)     begin errors++; $display("FAIL tmo_latency got %0d want 64", cyc); end
    checks++; if (done !== 1'b1)  begin errors++; $display("FAIL tmo_done got %b want 1", done); end
    checks++; if (tmo !== 1'b1)   begin errors++; $display("FAIL tmo_flag got %b want 1", tmo); end
    checks++; if (pass !== 1'b0)  begin errors++; $display("FAIL tmo_pass got %b want 0", pass); end
    checks++; if (req !== 1'b0)   begin errors++; $display("FAIL tmo_req got %b want 0", req); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL tmo_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_pass();
    int cyc, rb, wb, n;
    rb = rd_n;
    pulse_start();
    n = 0;
    while (rd_n - rb < 5 && n < 200) begin @(posedge clk); #1; n++; end
    checks++; if (rd_n - rb !== 5) begin errors++; $display("FAIL midrst_reach got %0d want 5", rd_n - rb); end
    rst = 1'b1; #1;
    checks++; if (req !== 1'b0)   begin errors++; $display("FAIL midrst_req got %b want 0", req); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL midrst_no_resume got %b want 0", busy); end
    wb = wr_n;
    pulse_start();
    wait_done(200, cyc);
    checks++; if (cyc !== 48)     begin errors++; $display("FAIL midrst_latency got %0d want 48", cyc); end
    checks++; if (pass !== 1'b1)  begin errors++; $display("FAIL midrst_pass got %b want 1", pass); end
    checks++; if (wr_n - wb !== 8) begin errors++; $display("FAIL midrst_wr_count got %0d want 8", wr_n - wb); end
  endtask

  task automatic test_wrap_and_busy_start();
    int cyc;
    logic [31:0] exp_a [4];
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0; exp_a[3] = 32'h4;
    @(posedge clk); #1 start6 = 1'b1;
    @(posedge clk); #1 start6 = 1'b0;
    cyc = 0;
    repeat (4) begin @(posedge clk); #1; cyc++; end
    start6 = 1'b1;
    @(posedge clk); #1 start6 = 1'b0; cyc++;
    while (!done6 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    checks++; if (cyc !== 24)     begin errors++; $display("FAIL wrap_latency got %0d want 24", cyc); end
    checks++; if (pass6 !== 1'b1) begin errors++; $display("FAIL wrap_pass got %b want 1", pass6); end
    checks++; if (w6_n !== 4)     begin errors++; $display("FAIL wrap_wr_count got %0d want 4", w6_n); end
    checks++; if (r6_n !== 4)     begin errors++; $display("FAIL wrap_rd_count got %0d want 4", r6_n); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (w6_log[k] !== exp_a[k]) begin errors++; $display("FAIL wrap_wr_addr%0d got %h want %h", k, w6_log[k], exp_a[k]); end
      checks++;
      if (r6_log[k] !== exp_a[k]) begin errors++; $display("FAIL wrap_rd_addr%0d got %h want %h", k, r6_log[k], exp_a[k]); end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk); #1;
    test_reset();
    test_basic();
    test_corrupt();
    test_gnt_stall();
    test_timeout();
    test_reset_mid_pass();
    test_wrap_and_busy_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
